// File: rtl/digit_to_number_module.sv
// Serial decimal-digit accumulator: MSD-first digits build an 8-bit value, committed on Enter.
// Optional backspace support is enabled by defining DIGIT_BACKSPACE_EN.
module digit_to_number_module #(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_VALUE  = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] Digit_Data,
  input  logic       Digit_Valid,
  input  logic       Enter,
  input  logic       Clear,
  input  logic       Back,
  output logic [7:0] Number_Data,
  output logic       Number_Valid,
  output logic [7:0] Acc_Data,
  output logic [2:0] Digit_Count,
  output logic       Error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ERROR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        do_clear;
  logic        do_enter;
  logic        do_back;
  logic        do_digit;
  logic [11:0] candidate;
  logic        digit_bad;

  logic [7:0]  acc_next;
  logic [2:0]  count_next;
  logic [7:0]  number_next;
  logic        valid_next;
  logic        error_next;

`ifdef DIGIT_BACKSPACE_EN
  logic [7:0]  acc_div10;
  logic [2:0]  count_dec;
`endif

  // Strobe priority Clear > Enter > Back > Digit; Back always masks a digit even when unused.
  always_comb begin
    do_clear  = Clear;
    do_enter  = Enter && !Clear;
    do_back   = Back && !Clear && !Enter;
    do_digit  = Digit_Valid && !Clear && !Enter && !Back;
    candidate = ({4'd0, Acc_Data} * 12'd10) + {8'd0, Digit_Data};
    digit_bad = (Digit_Data > 4'd9) ||
                (Digit_Count == 3'(MAX_DIGITS)) ||
                (candidate > 12'(MAX_VALUE));
  end

`ifdef DIGIT_BACKSPACE_EN
  always_comb begin
    acc_div10 = Acc_Data / 8'd10;
    count_dec = Digit_Count - 3'd1;
  end
`endif

  // State and all outputs are registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      Acc_Data     <= 8'd0;
      Digit_Count  <= 3'd0;
      Number_Data  <= 8'd0;
      Number_Valid <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= state_next;
      Acc_Data     <= acc_next;
      Digit_Count  <= count_next;
      Number_Data  <= number_next;
      Number_Valid <= valid_next;
      Error        <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    if (do_clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_digit) begin
            state_next = digit_bad ? ST_ERROR : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (do_enter) begin
            state_next = ST_IDLE;
          end else if (do_back) begin
`ifdef DIGIT_BACKSPACE_EN
            state_next = (count_dec == 3'd0) ? ST_IDLE : ST_ACCUM;
`else
            state_next = ST_ACCUM;
`endif
          end else if (do_digit) begin
            state_next = digit_bad ? ST_ERROR : ST_ACCUM;
          end
        end
        ST_ERROR: begin
          state_next = ST_ERROR;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ERROR freezes accumulator and count; only Clear leaves it.
  always_comb begin
    acc_next    = Acc_Data;
    count_next  = Digit_Count;
    number_next = Number_Data;
    valid_next  = 1'b0;
    error_next  = Error;
    if (do_clear) begin
      acc_next   = 8'd0;
      count_next = 3'd0;
      error_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (do_enter) begin
            if (state == ST_ACCUM) begin
              number_next = Acc_Data;
              valid_next  = 1'b1;
              acc_next    = 8'd0;
              count_next  = 3'd0;
            end
          end else if (do_back) begin
`ifdef DIGIT_BACKSPACE_EN
            if (state == ST_ACCUM) begin
              acc_next   = acc_div10;
              count_next = count_dec;
            end
`endif
          end else if (do_digit) begin
            if (digit_bad) begin
              error_next = 1'b1;
            end else begin
              acc_next   = candidate[7:0];
              count_next = Digit_Count + 3'd1;
            end
          end
        end
        default: begin
          error_next = Error;
        end
      endcase
    end
  end

endmodule
